// File: rtl/sne_evt_stream_pkg.sv
// Shared types for the SNE event-stream blocks.
//   uevent_t            : one event word as carried on an event stream
//   streamer_state_e    : control states of the memory-to-stream source
//   STREAMER_FIFO_DEPTH : output buffering of the memory streamer
package sne_evt_stream_pkg;

  typedef struct packed {
    logic [1:0]  op;
    logic [5:0]  unit_id;
    logic [7:0]  neuron_id;
    logic [15:0] tstamp;
  } uevent_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    ABORT
  } streamer_state_e;

  localparam int unsigned STREAMER_FIFO_DEPTH = 2;
  localparam int unsigned UEVENT_W            = $bits(uevent_t);

endpackage

// File: rtl/sne_evt_fifo2.sv
// Two-entry uevent_t FIFO feeding the streamer output.
// Entry 0 is always the head, so the stream output is a plain register.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata (accepted when not full, or when full with pop)
//   wdata    : event to write
//   pop      : remove the head (ignored when empty)
//   flush    : keep only a head that is not leaving this cycle, drop the rest
//              and any concurrent push
//   count    : number of stored entries (0..2)
//   valid    : FIFO holds at least one entry
//   head     : entry at the head of the FIFO
module sne_evt_fifo2
  import sne_evt_stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  uevent_t    wdata,
  input  logic       pop,
  input  logic       flush,
  output logic [1:0] count,
  output logic       valid,
  output uevent_t    head
);

  uevent_t    entry0;
  uevent_t    entry1;
  logic [1:0] cnt;
  logic [1:0] wr_idx;
  logic       do_pop;
  logic       do_push;

  always_comb begin
    do_pop  = pop && (cnt != 2'd0);
    do_push = push && ((cnt != 2'(STREAMER_FIFO_DEPTH)) || do_pop);
    wr_idx  = cnt - {1'b0, do_pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      entry0 <= '0;
      entry1 <= '0;
    end else if (flush) begin
      // A head that stays presented is retained in place; everything else goes.
      cnt <= ((cnt != 2'd0) && !do_pop) ? 2'd1 : 2'd0;
    end else begin
      if (do_pop) begin
        entry0 <= entry1;
      end
      if (do_push) begin
        if (wr_idx == 2'd0) begin
          entry0 <= wdata;
        end else begin
          entry1 <= wdata;
        end
      end
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign count = cnt;
  assign valid = (cnt != 2'd0);
  assign head  = entry0;

endmodule

// File: rtl/sne_evt_mem_streamer.sv
// Memory-to-stream event source: reads cfg_num_evt_i words starting at
// cfg_base_addr_i through a latency-1 memory read port and emits each one as
// a uevent_t on a valid/ready stream, one event per cycle when unstalled.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   cfg_start_i         : start pulse (IDLE only)
//   cfg_abort_i         : abort request (RUN/DRAIN only)
//   cfg_base_addr_i     : first word address
//   cfg_num_evt_i       : number of events in the run
//   busy_o              : run in progress
//   done_o              : one-cycle completion/abort pulse
//   aborted_o           : last run was terminated by abort
//   evt_cnt_o           : events handshaken in the current run
//   mem_addr_o          : read address
//   mem_enable_o        : read enable
//   mem_data_i          : read data, one cycle after enable
//   evt_valid_o/evt_o   : stream valid / event
//   evt_ready_i         : stream ready
module sne_evt_mem_streamer
  import sne_evt_stream_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned NW        = 16,
  parameter int unsigned ADDR_STEP = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cfg_start_i,
  input  logic          cfg_abort_i,
  input  logic [AW-1:0] cfg_base_addr_i,
  input  logic [NW-1:0] cfg_num_evt_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          aborted_o,
  output logic [NW-1:0] evt_cnt_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_enable_o,
  input  uevent_t       mem_data_i,
  output logic          evt_valid_o,
  output uevent_t       evt_o,
  input  logic          evt_ready_i
);

  streamer_state_e state;
  logic [AW-1:0]   rd_addr;
  logic [NW-1:0]   rd_left;
  logic [NW-1:0]   evt_cnt;
  logic            inflight;
  logic            done;
  logic            aborted;

  logic [1:0]      fifo_cnt;
  logic            fifo_valid;
  uevent_t         fifo_head;

  logic            hs;
  logic [2:0]      occ;
  logic            rd_en;
  logic            abort_req;
  logic            drain_done;
  logic            flush;

  always_comb begin
    hs         = fifo_valid && evt_ready_i;
    // Credit counts the head leaving this cycle, otherwise a 2-deep FIFO
    // could not sustain one event per cycle with a latency-1 memory.
    occ        = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, hs};
    abort_req  = cfg_abort_i && ((state == RUN) || (state == DRAIN));
    rd_en      = (state == RUN) && !cfg_abort_i && (rd_left != '0) &&
                 (occ < 3'(STREAMER_FIFO_DEPTH));
    // Completion is recognised on the final handshake so done follows it
    // by exactly one cycle; it takes priority over a coincident abort.
    drain_done = (state == DRAIN) && !inflight &&
                 ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && hs));
    flush      = abort_req && !drain_done;
  end

  sne_evt_fifo2 u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (inflight),
    .wdata (mem_data_i),
    .pop   (hs),
    .flush (flush),
    .count (fifo_cnt),
    .valid (fifo_valid),
    .head  (fifo_head)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      rd_addr  <= '0;
      rd_left  <= '0;
      evt_cnt  <= '0;
      inflight <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= rd_en;

      if (hs && (evt_cnt != '1)) begin
        evt_cnt <= evt_cnt + NW'(1);
      end

      if (rd_en) begin
        rd_addr <= rd_addr + AW'(ADDR_STEP);
        rd_left <= rd_left - NW'(1);
      end

      unique case (state)
        IDLE: begin
          if (cfg_start_i) begin
            rd_addr <= cfg_base_addr_i;
            rd_left <= cfg_num_evt_i;
            evt_cnt <= '0;
            aborted <= 1'b0;
            if (cfg_num_evt_i == '0) begin
              done <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (abort_req) begin
            state <= ABORT;
          end else if (rd_en && (rd_left == NW'(1))) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (abort_req) begin
            state <= ABORT;
          end
        end
        ABORT: begin
          // Only the event that was presented at abort time can remain.
          if (!fifo_valid || hs) begin
            state   <= IDLE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o       = (state != IDLE);
  assign done_o       = done;
  assign aborted_o    = aborted;
  assign evt_cnt_o    = evt_cnt;
  assign mem_addr_o   = rd_addr;
  assign mem_enable_o = rd_en;
  assign evt_valid_o  = fifo_valid;
  assign evt_o        = fifo_head;

endmodule

// File: tb/tb_sne_evt_mem_streamer.sv
// Scoreboard bench for sne_evt_mem_streamer: each run pushes the expected
// read addresses and event words into queues; a negedge monitor checks
// every read and every stream handshake against them.
module tb_sne_evt_mem_streamer;
  import sne_evt_stream_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic        cfg_abort;
  logic [31:0] cfg_base;
  logic [15:0] cfg_num;
  logic        busy, done, aborted;
  logic [15:0] evt_cnt;
  logic [31:0] mem_addr;
  logic        mem_enable;
  uevent_t     mem_data;
  logic        evt_valid;
  uevent_t     evt;
  logic        evt_ready;

  sne_evt_mem_streamer #(.AW(32), .NW(16), .ADDR_STEP(1)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cfg_start_i     (cfg_start),
    .cfg_abort_i     (cfg_abort),
    .cfg_base_addr_i (cfg_base),
    .cfg_num_evt_i   (cfg_num),
    .busy_o          (busy),
    .done_o          (done),
    .aborted_o       (aborted),
    .evt_cnt_o       (evt_cnt),
    .mem_addr_o      (mem_addr),
    .mem_enable_o    (mem_enable),
    .mem_data_i      (mem_data),
    .evt_valid_o     (evt_valid),
    .evt_o           (evt),
    .evt_ready_i     (evt_ready)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [31:0] seed;
  int          ready_mode = 0;
  int          rdy_k = 0;

  logic [31:0] exp_addr[$];
  uevent_t     exp_evt[$];

  int          start_cyc, first_en, last_en, first_val, done_cyc;
  int          done_seen = 0;
  int          n_rd, n_hs;
  bit          busy_seen, done_abort, prev_stall;
  uevent_t     prev_evt;

  function automatic uevent_t word_at(input logic [31:0] a);
    logic [31:0] w;
    w = (a * 32'h9E37_79B1) ^ seed;
    return uevent_t'(w);
  endfunction

  function automatic logic [63:0] ev64(input uevent_t e);
    return {32'b0, e};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Latency-1 memory; garbage on cycles without a read.
  always @(posedge clk)
    mem_data <= mem_enable ? word_at(mem_addr) : uevent_t'($urandom);

  initial begin
    evt_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rdy_k++;
      case (ready_mode)
        0:       evt_ready = 1'b1;
        1:       evt_ready = (rdy_k % 3 == 0);
        2:       evt_ready = ($urandom_range(0, 3) != 0);
        default: evt_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (busy) busy_seen = 1'b1;
      if (mem_enable) begin
        if (exp_addr.size() == 0) check("extra_read", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        else check("rd_addr", 64'(mem_addr), 64'(exp_addr.pop_front()));
        n_rd++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end
      if (evt_valid && first_val < 0) first_val = cyc;
      if (prev_stall) begin
        check("valid_held", 64'(evt_valid), 64'd1);
        check("evt_stable", ev64(evt), ev64(prev_evt));
      end
      if (evt_valid && evt_ready) begin
        if (exp_evt.size() == 0) check("extra_event", ev64(evt), 64'hFFFF_FFFF_FFFF_FFFF);
        else check("evt_word", ev64(evt), ev64(exp_evt.pop_front()));
        n_hs++;
      end
      check("outstanding_le2", 64'((n_rd - n_hs) > 2), 64'd0);
      prev_stall = evt_valid && !evt_ready;
      prev_evt   = evt;
      if (done) begin
        done_seen++;
        done_cyc   = cyc;
        done_abort = aborted;
      end
    end
  end

  // Called at #1 after a posedge; returns one cycle later with start low.
  task automatic start_run(input logic [31:0] base, input logic [15:0] num);
    logic [31:0] a;
    exp_addr.delete();
    exp_evt.delete();
    for (int unsigned i = 0; i < 32'(num); i++) begin
      a = base + i;
      exp_addr.push_back(a);
      exp_evt.push_back(word_at(a));
    end
    first_en = -1; last_en = -1; first_val = -1; done_cyc = -1;
    n_rd = 0; n_hs = 0; busy_seen = 1'b0; done_abort = 1'b0;
    cfg_base  = base;
    cfg_num   = num;
    cfg_start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0;
    n0 = done_seen;
    for (int i = 0; i < budget && done_seen == n0; i++) @(posedge clk);
    #1;
    if (done_seen == n0) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic finish_normal(input string tag, input logic [15:0] num);
    check({tag, "_evt_cnt"}, 64'(evt_cnt), 64'(num));
    check({tag, "_aborted"}, 64'(done_abort), 64'd0);
    check({tag, "_all_reads"}, 64'(exp_addr.size()), 64'd0);
    check({tag, "_all_events"}, 64'(exp_evt.size()), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic scenario_basic();
    ready_mode = 0;
    start_run(32'h100, 16'd4);
    wait_done(40);
    check("s1_first_en", 64'(first_en - start_cyc), 64'd1);
    check("s1_last_en", 64'(last_en - start_cyc), 64'd4);
    check("s1_first_valid", 64'(first_val - start_cyc), 64'd3);
    check("s1_done_cycle", 64'(done_cyc - start_cyc), 64'd7);
    finish_normal("s1", 16'd4);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_aborted"}, 64'(aborted), 64'd0);
    check({tag, "_evt_cnt"}, 64'(evt_cnt), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_en"}, 64'(mem_enable), 64'd0);
    check({tag, "_valid"}, 64'(evt_valid), 64'd0);
    check({tag, "_evt"}, ev64(evt), 64'd0);
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0;
    cfg_base = '0; cfg_num = '0;
    seed = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    scenario_basic();

    // Backpressure pattern 1,0,0,...
    ready_mode = 1;
    start_run($urandom, 16'd6);
    wait_done(100);
    finish_normal("bp", 16'd6);

    // Zero-count start.
    ready_mode = 0;
    start_run(32'h40, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    check("zero_done_cycle", 64'(done_cyc - start_cyc), 64'd1);
    check("zero_busy_seen", 64'(busy_seen), 64'd0);
    check("zero_reads", 64'(n_rd), 64'd0);

    // Abort while the first event is held by backpressure.
    ready_mode = 3;
    start_run($urandom, 16'd8);
    repeat (4) @(posedge clk);
    #1;
    cfg_abort = 1'b1;
    @(posedge clk); #1;
    cfg_abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_head_valid", 64'(evt_valid), 64'd1);
    check("abort_cnt_before", 64'(evt_cnt), 64'd0);
    ready_mode = 0;
    wait_done(30);
    check("abort_no_late_read", 64'(last_en > start_cyc + 5), 64'd0);
    check("abort_flag", 64'(done_abort), 64'd1);
    check("abort_evt_cnt", 64'(evt_cnt), 64'd1);
    check("abort_delivered", 64'(n_hs), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("abort_nothing_after", 64'(n_hs), 64'd1);

    // Address wrap.
    start_run(32'hFFFF_FFFE, 16'd3);
    wait_done(40);
    finish_normal("wrap", 16'd3);

    // Second start while busy must be ignored.
    start_run(32'h2000, 16'd5);
    @(posedge clk); #1;
    cfg_base = 32'hDEAD_0000; cfg_num = 16'd3; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    wait_done(40);
    finish_normal("restart", 16'd5);

    // Randomized runs under random backpressure.
    ready_mode = 2;
    for (int r = 0; r < 8; r++) begin
      logic [15:0] n;
      n = 16'($urandom_range(1, 10));
      start_run($urandom, n);
      wait_done(300);
      finish_normal("rand", n);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    // Reset in the middle of a run.
    ready_mode = 0;
    start_run($urandom, 16'd8);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_addr.delete();
    exp_evt.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    scenario_basic();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
